// File: rtl/decoder_stage.sv
// Instruction-decode stage: splits a 16-bit instruction into its fields and
// registers the control bundle consumed by the execute, memory and PC stages.
module decoder_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] instruction,
  output logic        MemoryWrite,
  output logic [1:0]  WriteRegFrom,
  output logic [3:0]  RegToWrite,
  output logic [7:0]  Immediate,
  output logic        writeMemFrom,
  output logic        RegWriteEnSc,
  output logic        RegWriteEnVec,
  output logic        OverWriteNz,
  output logic [2:0]  PcWriteEn,
  output logic [2:0]  AluOpCode
);

  typedef enum logic [3:0] {
    OP_LOSC  = 4'h0,
    OP_XOR   = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_MUL   = 4'h4,
    OP_RSHF  = 4'h5,
    OP_LSHF  = 4'h6,
    OP_INC   = 4'h7,
    OP_JE    = 4'h8,
    OP_JNE   = 4'h9,
    OP_JMP   = 4'hA,
    OP_SVPIX = 4'hC,
    OP_LOPIX = 4'hD,
    OP_LMEM  = 4'hF
  } opcode_t;

  localparam logic [1:0] SRC_MEM = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;
  localparam logic [1:0] SRC_IMM = 2'd2;

  typedef struct packed {
    logic       memoryWrite;
    logic [1:0] writeRegFrom;
    logic [3:0] regToWrite;
    logic [7:0] immediate;
    logic       writeMemFrom;
    logic       regWriteEnSc;
    logic       regWriteEnVec;
    logic       overWriteNz;
    logic [2:0] pcWriteEn;
    logic [2:0] aluOpCode;
  } ctrlBundle_t;

  ctrlBundle_t decoded;
  ctrlBundle_t bundleQ;

  always_comb begin
    // NOTE: defaulting every field first keeps this block latch-free and makes
    // undefined or X/Z opcodes fall through to the NOP bundle.
    decoded            = '0;
    decoded.regToWrite = instruction[11:8];
    decoded.immediate  = instruction[7:0];
    case (instruction[15:12])
      OP_LOSC: begin
        decoded.regWriteEnSc = 1'b1;
        decoded.writeRegFrom = SRC_IMM;
      end
      OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_RSHF, OP_LSHF: begin
        decoded.aluOpCode     = instruction[14:12];
        decoded.regWriteEnVec = 1'b1;
        decoded.writeRegFrom  = SRC_ALU;
        decoded.overWriteNz   = 1'b1;
      end
      OP_INC: begin
        decoded.aluOpCode    = 3'd7;
        decoded.regWriteEnSc = 1'b1;
        decoded.writeRegFrom = SRC_ALU;
        decoded.overWriteNz  = 1'b1;
      end
      OP_JE:  decoded.pcWriteEn = 3'b010;
      OP_JNE: decoded.pcWriteEn = 3'b001;
      OP_JMP: decoded.pcWriteEn = 3'b100;
      OP_SVPIX: begin
        decoded.memoryWrite  = 1'b1;
        decoded.writeMemFrom = 1'b1;
      end
      OP_LOPIX: begin
        decoded.regWriteEnVec = 1'b1;
        decoded.writeRegFrom  = SRC_MEM;
        decoded.writeMemFrom  = 1'b1;
      end
      OP_LMEM: begin
        decoded.regWriteEnSc = 1'b1;
        decoded.writeRegFrom = SRC_MEM;
      end
      default: ;
    endcase
  end

  // Flush wins over stall so a squashed slot never survives a held pipeline.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of its inputs, independent of statement order.
    if (rst)         bundleQ <= '0;
    else if (flush)  bundleQ <= '0;
    else if (!stall) bundleQ <= decoded;
  end

  assign MemoryWrite   = bundleQ.memoryWrite;
  assign WriteRegFrom  = bundleQ.writeRegFrom;
  assign RegToWrite    = bundleQ.regToWrite;
  assign Immediate     = bundleQ.immediate;
  assign writeMemFrom  = bundleQ.writeMemFrom;
  assign RegWriteEnSc  = bundleQ.regWriteEnSc;
  assign RegWriteEnVec = bundleQ.regWriteEnVec;
  assign OverWriteNz   = bundleQ.overWriteNz;
  assign PcWriteEn     = bundleQ.pcWriteEn;
  assign AluOpCode     = bundleQ.aluOpCode;

endmodule

// File: tb/tb_decoder_stage.sv
// Scoreboard bench for decoder_stage: a table-driven reference model feeds an
// expectation queue that a free-running monitor drains one entry per clock.
module tb_decoder_stage;

  typedef struct packed {
    logic       mw;
    logic [1:0] wrf;
    logic [3:0] rd;
    logic [7:0] imm;
    logic       wmf;
    logic       sc;
    logic       vec;
    logic       nz;
    logic [2:0] pc;
    logic [2:0] alu;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instruction = '0;
  logic        MemoryWrite;
  logic [1:0]  WriteRegFrom;
  logic [3:0]  RegToWrite;
  logic [7:0]  Immediate;
  logic        writeMemFrom;
  logic        RegWriteEnSc;
  logic        RegWriteEnVec;
  logic        OverWriteNz;
  logic [2:0]  PcWriteEn;
  logic [2:0]  AluOpCode;

  int    checks = 0;
  int    errors = 0;
  ctrl_t expQ[$];
  ctrl_t refTable [16];
  ctrl_t modelState;
  bit    done = 1'b0;

  decoder_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .instruction(instruction),
    .MemoryWrite(MemoryWrite), .WriteRegFrom(WriteRegFrom), .RegToWrite(RegToWrite),
    .Immediate(Immediate), .writeMemFrom(writeMemFrom), .RegWriteEnSc(RegWriteEnSc),
    .RegWriteEnVec(RegWriteEnVec), .OverWriteNz(OverWriteNz), .PcWriteEn(PcWriteEn),
    .AluOpCode(AluOpCode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic ctrl_t sampleDut();
    ctrl_t s;
    s = '{mw: MemoryWrite, wrf: WriteRegFrom, rd: RegToWrite, imm: Immediate,
          wmf: writeMemFrom, sc: RegWriteEnSc, vec: RegWriteEnVec, nz: OverWriteNz,
          pc: PcWriteEn, alu: AluOpCode};
    return s;
  endfunction

  function automatic ctrl_t row(input logic mw, input logic [1:0] wrf, input logic wmf,
                                input logic sc, input logic vec, input logic nz,
                                input logic [2:0] pc, input logic [2:0] alu);
    ctrl_t r;
    r = '{mw: mw, wrf: wrf, rd: 4'h0, imm: 8'h00, wmf: wmf, sc: sc, vec: vec,
          nz: nz, pc: pc, alu: alu};
    return r;
  endfunction

  function automatic ctrl_t refDecode(input logic [15:0] ins);
    ctrl_t r;
    r     = refTable[ins[15:12]];
    r.rd  = ins[11:8];
    r.imm = ins[7:0];
    return r;
  endfunction

  // Drive one cycle of stimulus and record what the stage must show after the edge.
  task automatic apply(input logic [15:0] ins, input logic st, input logic fl);
    @(negedge clk);
    instruction = ins;
    stall       = st;
    flush       = fl;
    if (fl)       modelState = '0;
    else if (!st) modelState = refDecode(ins);
    expQ.push_back(modelState);
  endtask

  task automatic checkResetZero(input string name);
    check(name, 64'(sampleDut()), 64'(0));
  endtask

  initial begin : monitor
    ctrl_t exp, act;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        act = sampleDut();
        check("bundle", 64'(act), 64'(exp));
        check("pc_onehot0", 64'($countones(act.pc) <= 1), 64'(1));
        check("rf_exclusive", 64'(act.sc & act.vec), 64'(0));
        check("mw_no_rf", 64'(act.mw & (act.sc | act.vec)), 64'(0));
      end
    end
  end

  initial begin : watchdog
    #500000;
    if (!done) begin
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin : stimulus
    logic [15:0] directed [] = '{16'h0612, 16'h3260, 16'hA015, 16'h8010, 16'h9032,
                                 16'h1370, 16'h2190, 16'h4370, 16'h5160, 16'h6250,
                                 16'h7E00, 16'hD200, 16'hC300, 16'hB000, 16'hE000};
    // Opcode table: mw, wrf, wmf, sc, vec, nz, pc, alu
    for (int op = 0; op < 16; op++) refTable[op] = '0;
    refTable[4'h0] = row(0, 2, 0, 1, 0, 0, 3'b000, 0);
    for (int op = 1; op <= 6; op++)
      refTable[op] = row(0, 1, 0, 0, 1, 1, 3'b000, 3'(op));
    refTable[4'h7] = row(0, 1, 0, 1, 0, 1, 3'b000, 7);
    refTable[4'h8] = row(0, 0, 0, 0, 0, 0, 3'b010, 0);
    refTable[4'h9] = row(0, 0, 0, 0, 0, 0, 3'b001, 0);
    refTable[4'hA] = row(0, 0, 0, 0, 0, 0, 3'b100, 0);
    refTable[4'hC] = row(1, 0, 1, 0, 0, 0, 3'b000, 0);
    refTable[4'hD] = row(0, 0, 1, 0, 1, 0, 3'b000, 0);
    refTable[4'hF] = row(0, 0, 0, 1, 0, 0, 3'b000, 0);
    modelState = '0;

    instruction = 16'h3260;
    #1;
    checkResetZero("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    apply(16'h3260, 0, 0);
    apply(16'hA015, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetZero("reset_async");
    @(posedge clk);
    #2;
    checkResetZero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    modelState = '0;

    apply(16'hF510, 0, 0);
    foreach (directed[i]) apply(directed[i], 0, 0);

    apply(16'h2190, 0, 0);
    apply(16'hC300, 1, 0);
    apply(16'h9032, 1, 0);
    apply(16'h7E00, 1, 1);
    apply(16'h0612, 1, 0);
    apply(16'h0612, 0, 0);

    for (int n = 0; n < 400; n++)
      apply(16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(expQ.size()), 64'(0));
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
